// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, opcode width and FSM state type shared by the
// ALU sharing arbiter and its users.
package alu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_MUL = 3'b010;
    localparam logic [OPW-1:0] OP_AND = 3'b011;
    localparam logic [OPW-1:0] OP_OR  = 3'b100;
    localparam logic [OPW-1:0] OP_SLL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant selection; searches upward from ptr,
// wrapping, and returns the first valid requester as one-hot and index.
module alu_arb_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    logic [IDXW:0]   sum_s;
    logic [IDXW-1:0] cand_s;

    // Rotating first-valid search starting at the pointer
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum_s = {1'b0, ptr} + (IDXW+1)'(off);
            if (sum_s >= (IDXW+1)'(NREQ)) begin
                cand_s = IDXW'(sum_s - (IDXW+1)'(NREQ));
            end else begin
                cand_s = sum_s[IDXW-1:0];
            end
            if (!any && valid[cand_s]) begin
                any       = 1'b1;
                grant_idx = cand_s;
            end else begin
                grant_idx = grant_idx;
            end
        end
        grant[grant_idx] = any;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU among NREQ requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [W-1:0]        rsp_result,
    output logic                rsp_zero,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [OPW-1:0]      alu_op,
    input  logic [W-1:0]        alu_result,
    input  logic                alu_zero
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_r, state_s;
    logic [W-1:0]    a_r, b_r, result_r;
    logic [OPW-1:0]  op_r;
    logic            zero_r;
    logic [IDXW-1:0] grant_r, ptr_s, pick_idx_s;
    logic [NREQ-1:0] pick_grant_s;
    logic            pick_any_s;
    logic            rsp_done_s;

    assign rsp_done_s = (state_r == RESP) && rsp_ready[grant_r];

`ifdef ALU_ARB_RR_EN
    logic [IDXW-1:0] ptr_r;

    // Round-robin pointer moves just past the requester that completed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (rsp_done_s) begin
            if (grant_r == IDXW'(NREQ-1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_r + IDXW'(1);
            end
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    alu_arb_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr_s),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .any       (pick_any_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) state_s = EXEC;
                else            state_s = IDLE;
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (rsp_done_s) state_s = IDLE;
                else            state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture on accept and result capture after the ALU cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            grant_r  <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
        end else begin
            if (state_r == IDLE && pick_any_s) begin
                a_r     <= req_a[pick_idx_s*W +: W];
                b_r     <= req_b[pick_idx_s*W +: W];
                op_r    <= req_op[pick_idx_s*OPW +: OPW];
                grant_r <= pick_idx_s;
            end
            if (state_r == EXEC) begin
                result_r <= alu_result;
                zero_r   <= alu_zero;
            end
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_r == IDLE) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = '0;
        end
        if (state_r == RESP) begin
            rsp_valid[grant_r] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign alu_op     = op_r;
    assign rsp_result = result_r;
    assign rsp_zero   = zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a response scoreboard and a
// behavioural ALU hung off the arbiter's ALU port.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [W-1:0]        rsp_result;
    logic                rsp_zero;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [OPW-1:0]      alu_op;
    logic [W-1:0]        alu_result;
    logic                alu_zero;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        z;
    } sb_entry_t;

    sb_entry_t   sb[$];
    sb_entry_t   mon_e;
    int          total = 0;
    int          bad   = 0;
    int          exp_ptr = 0;
    int          g;
    logic [1:0]  one = 2'b01;

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External single-cycle ALU
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_MUL:  alu_result = alu_a * alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one transaction from an idle arbiter and checks its full timeline
    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] er, input logic ez);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_op[idx*3 +: 3]  = op;
        req_valid[idx]      = 1'b1;
        sb.push_back('{idx, er, ez});
        #1;
        chk("req_ready", req_ready, one << idx);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", alu_op, op);
        chk("exec_no_rsp", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, one << idx);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", rsp_zero, ez);
        rsp_ready = one << idx;
        @(posedge clk); #1;
        rsp_ready = '0;
        chk("rsp_drop", rsp_valid, 0);
        exp_ptr = (idx == 1) ? 0 : 1;
    endtask

    // Scoreboard pop on every response handshake, plus one-hot checks
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_onehot0", 64'($onehot0(req_ready)), 1);
            chk("valid_onehot0", 64'($onehot0(rsp_valid)), 1);
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", rsp_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_idx", rsp_valid, one << mon_e.idx);
                    chk("sb_result", rsp_result, mon_e.res);
                    chk("sb_zero", rsp_zero, mon_e.z);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ops, zero flag, undefined opcodes
        run_one(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
        run_one(1, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1);
        run_one(0, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1);
        run_one(1, 32'd8, 32'd2, 3'b110, 32'd0, 1'b1);
        run_one(1, 32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND, 32'h00F0_1234, 1'b0);

        // Back-to-back from the same requester; SLL uses only B[4:0]
        run_one(0, 32'd6, 32'd7, OP_MUL, 32'd42, 1'b0);
        run_one(0, 32'd1, 32'd33, OP_SLL, 32'd2, 1'b0);

        // Backpressure: response held for 5 cycles while requester 1 waits
        req_a[31:0] = 32'd100;
        req_b[31:0] = 32'd23;
        req_op[2:0] = OP_ADD;
        req_valid   = 2'b01;
        sb.push_back('{0, 32'd123, 1'b0});
        #1;
        chk("bp_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid    = 2'b00;
        req_a[63:32] = 32'd7;
        req_b[63:32] = 32'd3;
        req_op[5:3]  = OP_SUB;
        req_valid[1] = 1'b1;
        sb.push_back('{1, 32'd4, 1'b0});
        chk("bp_exec_ready", req_ready, 0);
        @(posedge clk); #1;
        repeat (4) begin
            chk("bp_valid", rsp_valid, 2'b01);
            chk("bp_result", rsp_result, 32'd123);
            chk("bp_no_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        chk("bp_valid_last", rsp_valid, 2'b01);
        chk("bp_result_last", rsp_result, 32'd123);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        exp_ptr   = 1;
        chk("bp_next_ready", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("bp_r1_valid", rsp_valid, 2'b10);
        chk("bp_r1_result", rsp_result, 32'd4);
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        exp_ptr   = 0;

        // Contention: both valid continuously, responses always accepted
        req_a[31:0]  = 32'd1;
        req_b[31:0]  = 32'd1;
        req_op[2:0]  = OP_ADD;
        req_a[63:32] = 32'd10;
        req_b[63:32] = 32'd20;
        req_op[5:3]  = OP_ADD;
        req_valid    = 2'b11;
        rsp_ready    = 2'b11;
        for (int t = 0; t < 4; t++) begin
            #1;
`ifdef ALU_ARB_RR_EN
            g = exp_ptr;
`else
            g = 0;
`endif
            chk("contend_grant", req_ready, one << g);
            sb.push_back('{g, (g == 1) ? 32'd30 : 32'd2, 1'b0});
            repeat (3) @(posedge clk);
            #1;
            exp_ptr = (g == 1) ? 0 : 1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk); #1;

        // Reset while in EXEC: transaction dropped, outputs cleared at once
        req_a[31:0] = 32'd55;
        req_b[31:0] = 32'd66;
        req_op[2:0] = OP_MUL;
        req_valid   = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("pre_rst_alu_a", alu_a, 32'd55);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exp_ptr   = 0;
        rsp_ready = 2'b11;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 2'b00;
        run_one(1, 32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1'b1);
        run_one(0, 32'h0000_0F00, 32'h0000_00F0, OP_OR, 32'h0000_0FF0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
